sccb_responder: RTL and testbench

- SCCB target (camera-side responder) for the OV7670 register-load bus.
- Oversamples `sioc`/`siod` on the system clock and decodes 3-phase write and 2-phase read transactions.
- Presents each completed register write as a one-cycle strobe; drives `siod` low for ACK and read data.
- Used as a camera stand-in in simulation and on-board loopback, so the OV7670 controller can be exercised without a sensor.

---
 rtl/sccb_responder.sv | 194 +++++++++++++++++++
 tb/tb_sccb_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_responder.sv
// SCCB target standing in for an OV7670: decodes 3-phase writes, ACKs them and strobes each register write.
// Define SCCB_READBACK_EN to ACK the read ID (DEVICE_ID|1) and shift rd_data out on siod.
module sccb_responder #(
  parameter logic [7:0]  DEVICE_ID   = 8'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sioc_in,
  input  logic        siod_in,
  output logic        siod_drive_low,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] write_count
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, ADDR, ADDR_ACK, DATA, DATA_ACK, RD_BITS, RD_NA, WAIT_STOP
  } state_t;

  // Sync chains reset to the idle-bus level so reset release never looks like an edge.
  logic [SYNC_STAGES-1:0] sioc_sync_q, siod_sync_q;
  logic                   sioc_prev_q, siod_prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
    end else begin
      sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc_in};
      siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_in};
      sioc_prev_q <= sioc_sync_q[SYNC_STAGES-1];
      siod_prev_q <= siod_sync_q[SYNC_STAGES-1];
    end
  end

  logic sioc_s, siod_s, sioc_rise, sioc_fall, start_det, stop_det;
  assign sioc_s    = sioc_sync_q[SYNC_STAGES-1];
  assign siod_s    = siod_sync_q[SYNC_STAGES-1];
  assign sioc_rise = sioc_s & ~sioc_prev_q;
  assign sioc_fall = ~sioc_s & sioc_prev_q;
  assign start_det = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
  assign stop_det  = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;

  state_t      state_q;
  logic [6:0]  shift_q;
  logic [3:0]  cnt_q;
  logic        drive_q, wr_valid_q, busy_q;
  logic [7:0]  wr_addr_q, wr_data_q, ptr_q;
  logic [15:0] write_count_q;
`ifdef SCCB_READBACK_EN
  logic        rd_mode_q;
  logic [7:0]  tx_q;
`else
  logic        unused_rd_data;
  assign unused_rd_data = ^rd_data;
`endif

  logic [7:0] rx_byte_d;
  logic       last_bit_d, id_match_d;
  assign rx_byte_d  = {shift_q, siod_s};
  assign last_bit_d = (cnt_q == 4'd7);
  assign id_match_d = (rx_byte_d[7:1] == DEVICE_ID[7:1]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      drive_q       <= 1'b0;
      wr_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      ptr_q         <= '0;
      write_count_q <= '0;
`ifdef SCCB_READBACK_EN
      rd_mode_q     <= 1'b0;
      tx_q          <= '0;
`endif
    end else begin
      wr_valid_q <= 1'b0;
      if (stop_det) begin
        state_q <= IDLE;
        drive_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_det) begin
        state_q <= ID;
        cnt_q   <= '0;
        drive_q <= 1'b0;
        busy_q  <= 1'b1;
`ifdef SCCB_READBACK_EN
        rd_mode_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ID, ADDR, DATA: begin
            if (sioc_rise) begin
              shift_q <= rx_byte_d[6:0];
              cnt_q   <= last_bit_d ? 4'd0 : cnt_q + 4'd1;
              if (last_bit_d) begin
                if (state_q == ID) begin
                  if (!id_match_d) begin
                    state_q <= WAIT_STOP;
                  end else if (!rx_byte_d[0]) begin
                    state_q <= ID_ACK;
                  end else begin
`ifdef SCCB_READBACK_EN
                    rd_mode_q <= 1'b1;
                    state_q   <= ID_ACK;
`else
                    state_q   <= WAIT_STOP;
`endif
                  end
                end else if (state_q == ADDR) begin
                  ptr_q   <= rx_byte_d;
                  state_q <= ADDR_ACK;
                end else begin
                  wr_valid_q    <= 1'b1;
                  wr_addr_q     <= ptr_q;
                  wr_data_q     <= rx_byte_d;
                  write_count_q <= write_count_q + 16'd1;
                  state_q       <= DATA_ACK;
                end
              end
            end
          end
          // First fall after bit 8 pulls low; the next fall ends the ACK slot.
          ID_ACK, ADDR_ACK, DATA_ACK: begin
            if (sioc_fall) begin
              if (!drive_q) begin
                drive_q <= 1'b1;
              end else begin
                drive_q <= 1'b0;
                cnt_q   <= '0;
                if (state_q == ADDR_ACK) begin
                  state_q <= DATA;
                end else if (state_q == DATA_ACK) begin
                  state_q <= WAIT_STOP;
                end else begin
`ifdef SCCB_READBACK_EN
                  if (rd_mode_q) begin
                    tx_q    <= rd_data;
                    drive_q <= ~rd_data[7];
                    state_q <= RD_BITS;
                  end else begin
                    state_q <= ADDR;
                  end
`else
                  state_q <= ADDR;
`endif
                end
              end
            end
          end
`ifdef SCCB_READBACK_EN
          RD_BITS: begin
            if (sioc_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (sioc_fall) begin
              if (cnt_q == 4'd8) begin
                drive_q <= 1'b0;
                state_q <= RD_NA;
              end else begin
                tx_q    <= {tx_q[6:0], 1'b0};
                drive_q <= ~tx_q[6];
              end
            end
          end
          RD_NA: begin
            if (sioc_rise) state_q <= WAIT_STOP;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign siod_drive_low = drive_q;
  assign wr_valid       = wr_valid_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign rd_addr        = ptr_q;
  assign busy           = busy_q;
  assign write_count    = write_count_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: a bit-banged SCCB master drives directed transactions; a monitor
// pops expected writes from a scoreboard queue whenever wr_valid fires.
module tb_sccb_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sioc_m, sda_m;
  logic [7:0]  rd_data;
  logic        siod_drive_low, wr_valid, busy;
  logic [7:0]  wr_addr, wr_data, rd_addr;
  logic [15:0] write_count;
  logic        siod_pad;

  always #20 clk = ~clk;  // 25 MHz

  assign siod_pad = sda_m & ~siod_drive_low;

  sccb_responder #(.DEVICE_ID(8'h42), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .sioc_in        (sioc_m),
    .siod_in        (siod_pad),
    .siod_drive_low (siod_drive_low),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .busy           (busy),
    .write_count    (write_count)
  );

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int checks = 0;
  int errors = 0;
  int q_clks = 6;
  int drive_pulses = 0;
  int drive_cycles = 0;
  logic drive_prev = 1'b0;

  always @(negedge clk) begin
    if (siod_drive_low) drive_cycles++;
    if (siod_drive_low && !drive_prev) drive_pulses++;
    drive_prev = siod_drive_low;
    if (wr_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%02h data=%02h, required no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          errors++;
          $display("FAIL wr_beat: got addr=%02h data=%02h, required addr=%02h data=%02h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end else begin
          $display("write addr=%02h data=%02h ok", wr_addr, wr_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (sioc_m == 1'b0) begin
      sda_m = 1'b1; wait_clks(q_clks);
      sioc_m = 1'b1; wait_clks(q_clks);
    end
    sda_m = 1'b0; wait_clks(q_clks);
    sioc_m = 1'b0; wait_clks(q_clks);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clks(q_clks);
    sioc_m = 1'b1; wait_clks(q_clks);
    sda_m = 1'b1; wait_clks(2 * q_clks);
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    sda_m = b;     wait_clks(q_clks);
    sioc_m = 1'b1; wait_clks(q_clks);
    sampled = siod_pad; wait_clks(q_clks);
    sioc_m = 1'b0; wait_clks(q_clks);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic s;
    for (int i = 7; i > 7 - n; i--) clock_bit(b[i], s);
  endtask

  task automatic read_byte(output logic [7:0] b, output logic na_released);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(1'b1, s);
    na_released = s;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_drive"}, {31'd0, siod_drive_low}, 32'd0);
    check({tag, "_wr_valid"}, {31'd0, wr_valid}, 32'd0);
    check({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_rd_addr"}, {24'd0, rd_addr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_write_count"}, {16'd0, write_count}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1, a2, a3, na;
    logic [7:0] rb;
    int p0, c0;

    resetn = 1'b0; sioc_m = 1'b1; sda_m = 1'b1; rd_data = 8'hA5;
    wait_clks(5);
    check_all_zero("reset");
    resetn = 1'b1;
    wait_clks(5);

    // 1: plain 3-phase write at 100 kHz
    q_clks = 62;
    p0 = drive_pulses;
    exp_q.push_back('{addr: 8'h12, data: 8'h80});
    bus_start();
    check("t1_busy_in", {31'd0, busy}, 32'd1);
    send_byte(8'h42, a0); send_byte(8'h12, a1); send_byte(8'h80, a2);
    bus_stop();
    check("t1_acks", {29'd0, a0, a1, a2}, 32'h7);
    check("t1_ack_pulses", drive_pulses - p0, 32'd3);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_write_count", {16'd0, write_count}, 32'd1);
    check("t1_queue_empty", exp_q.size(), 32'd0);
    $display("t1 write 42/12/80 done");

    // 2: foreign ID is never ACKed and produces no write
    q_clks = 6;
    p0 = drive_pulses;
    bus_start();
    send_byte(8'h60, a0); send_byte(8'h12, a1); send_byte(8'h80, a2);
    check("t2_busy_in", {31'd0, busy}, 32'd1);
    bus_stop();
    check("t2_acks", {29'd0, a0, a1, a2}, 32'h0);
    check("t2_ack_pulses", drive_pulses - p0, 32'd0);
    check("t2_busy_after", {31'd0, busy}, 32'd0);
    check("t2_write_count", {16'd0, write_count}, 32'd1);
    $display("t2 foreign id 60 done");

    // 3: 2-phase pointer write then read ID
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h0A, a1);
    bus_stop();
    check("t3_acks", {30'd0, a0, a1}, 32'h3);
    check("t3_rd_addr", {24'd0, rd_addr}, 32'h0A);
    c0 = drive_cycles;
    bus_start();
    send_byte(8'h43, a2);
    read_byte(rb, na);
    bus_stop();
`ifdef SCCB_READBACK_EN
    check("t3_read_ack", {31'd0, a2}, 32'd1);
    check("t3_read_byte", {24'd0, rb}, 32'hA5);
    check("t3_na_released", {31'd0, na}, 32'd1);
`else
    check("t3_read_ack", {31'd0, a2}, 32'd0);
    check("t3_read_drive_cycles", drive_cycles - c0, 32'd0);
    check("t3_read_byte", {24'd0, rb}, 32'hFF);
`endif
    check("t3_rd_addr_kept", {24'd0, rd_addr}, 32'h0A);
    check("t3_write_count", {16'd0, write_count}, 32'd1);
    $display("t3 readback sequence done");

    // 4: STOP after 4 data bits loses the write
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h55, a1);
    send_bits(8'hA0, 4);
    bus_stop();
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_write_count", {16'd0, write_count}, 32'd1);
    check("t4_rd_addr", {24'd0, rd_addr}, 32'h55);
    $display("t4 truncated data done");

    // 5: repeated START restarts ID decoding but keeps the pointer
    exp_q.push_back('{addr: 8'h3A, data: 8'h04});
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h11, a1);
    bus_start();
    send_byte(8'h42, a2);
    check("t5_ptr_retained", {24'd0, rd_addr}, 32'h11);
    send_byte(8'h3A, a3); send_byte(8'h04, na);
    bus_stop();
    check("t5_acks", {27'd0, a0, a1, a2, a3, na}, 32'h1F);
    check("t5_write_count", {16'd0, write_count}, 32'd2);
    $display("t5 repeated start done");

    // 6: bytes after DATA_ACK are ignored
    exp_q.push_back('{addr: 8'h20, data: 8'h33});
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h20, a1); send_byte(8'h33, a2); send_byte(8'h44, a3);
    bus_stop();
    check("t6_acks", {28'd0, a0, a1, a2, a3}, 32'hE);
    check("t6_write_count", {16'd0, write_count}, 32'd3);
    $display("t6 extra byte ignored done");

    // 7: asynchronous reset in the middle of ADDR, then a clean write
    bus_start();
    send_byte(8'h42, a0);
    send_bits(8'hE0, 3);
    #5 resetn = 1'b0;
    #1 check_all_zero("t7_async");
    sioc_m = 1'b1; sda_m = 1'b1;
    wait_clks(4);
    resetn = 1'b1;
    wait_clks(4);
    exp_q.push_back('{addr: 8'h40, data: 8'hD0});
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h40, a1); send_byte(8'hD0, a2);
    bus_stop();
    check("t7_acks", {29'd0, a0, a1, a2}, 32'h7);
    check("t7_write_count", {16'd0, write_count}, 32'd1);
    check("t7_rd_addr", {24'd0, rd_addr}, 32'h40);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("t7 reset recovery done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
